// File: rtl/fifo_fwft.sv
// Synchronous FIFO with full-depth occupancy, selectable first-word-fall-through
// or standard read, watermark flags and sticky overflow/underflow errors.
module fifo_fwft #(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 6,
  parameter bit FWFT       = 1'b1,
  parameter int AF_LEVEL   = 48,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  wr_en_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  input  logic                  rd_en_i,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   elemcnt_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d, live;
  logic full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic wr_acc, rd_acc;

  assign wr_acc = wr_en_i && !full_q;
  assign rd_acc = rd_en_i && !empty_q;
  // Words that were already stored before this edge and survive it; a word
  // written at this edge only becomes readable one edge later.
  assign live   = cnt_q - CW'(rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    empty_d  = 1'b1;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + CW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + CW'(1);
      if (wr_en_i && full_q)  ovf_d = 1'b1;
      if (rd_en_i && empty_q) unf_d = 1'b1;
      empty_d = (live == '0);
    end
    cnt_d  = wr_ptr_d - rd_ptr_d;
    full_d = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
             (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
    af_d   = (cnt_d >= AF_L);
    ae_d   = (cnt_d <= AE_L);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc && !clr_i) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= din_i;
  end

  // FWFT prefetches the next head from the old memory contents, so a word
  // written this edge reaches dout one edge later, together with !empty.
  generate
    if (FWFT) begin : g_fwft
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)    dout_q <= '0;
        else if (!clr_i) dout_q <= mem_q[rd_ptr_d[ADDR_WIDTH-1:0]];
      end
    end else begin : g_std
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                dout_q <= '0;
        else if (!clr_i && rd_acc)   dout_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
    end
  endgenerate

  assign full_o         = full_q;
  assign almost_full_o  = af_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = ae_q;
  assign elemcnt_o      = cnt_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
  assign dout_o         = dout_q;
endmodule

// File: tb/tb_fifo_fwft.sv
// Randomised bench for fifo_fwft: FWFT and standard instances share stimulus and
// are checked every cycle against a queue-based model, plus literal pins.
module tb_fifo_fwft;
  localparam int DW = 72, AW = 6, DEPTH = 64;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic f1_full, f1_af, f1_empty, f1_ae, f1_ovf, f1_unf;
  logic f0_full, f0_af, f0_empty, f0_ae, f0_ovf, f0_unf;
  logic [DW-1:0] f1_dout, f0_dout;
  logic [AW:0] f1_cnt, f0_cnt;

  fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1), .AF_LEVEL(48), .AE_LEVEL(4)) u_f1 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .din_i(din), .wr_en_i(wr_en),
    .full_o(f1_full), .almost_full_o(f1_af), .dout_o(f1_dout), .rd_en_i(rd_en),
    .empty_o(f1_empty), .almost_empty_o(f1_ae), .elemcnt_o(f1_cnt),
    .overflow_o(f1_ovf), .underflow_o(f1_unf));

  fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0), .AF_LEVEL(48), .AE_LEVEL(4)) u_f0 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .din_i(din), .wr_en_i(wr_en),
    .full_o(f0_full), .almost_full_o(f0_af), .dout_o(f0_dout), .rd_en_i(rd_en),
    .empty_o(f0_empty), .almost_empty_o(f0_ae), .elemcnt_o(f0_cnt),
    .overflow_o(f0_ovf), .underflow_o(f0_unf));

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout0;
  bit m_empty, m_ovf, m_unf;
  int checks = 0, errors = 0;

  function automatic logic [DW-1:0] rnd72();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("cnt1",   DW'(f1_cnt),   DW'(n));
    chk("cnt0",   DW'(f0_cnt),   DW'(n));
    chk("full1",  DW'(f1_full),  DW'(n == DEPTH));
    chk("full0",  DW'(f0_full),  DW'(n == DEPTH));
    chk("af1",    DW'(f1_af),    DW'(n >= 48));
    chk("af0",    DW'(f0_af),    DW'(n >= 48));
    chk("ae1",    DW'(f1_ae),    DW'(n <= 4));
    chk("ae0",    DW'(f0_ae),    DW'(n <= 4));
    chk("empty1", DW'(f1_empty), DW'(m_empty));
    chk("empty0", DW'(f0_empty), DW'(m_empty));
    chk("ovf1",   DW'(f1_ovf),   DW'(m_ovf));
    chk("ovf0",   DW'(f0_ovf),   DW'(m_ovf));
    chk("unf1",   DW'(f1_unf),   DW'(m_unf));
    chk("unf0",   DW'(f0_unf),   DW'(m_unf));
    chk("dout0",  f0_dout, m_dout0);
    if (!m_empty) chk("dout_fwft", f1_dout, q[0]);
  endtask

  // Model: empty after an edge means no word that predates the edge remains.
  task automatic model(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    bit wa, ra;
    int old;
    if (c) begin
      q.delete(); m_empty = 1; m_ovf = 0; m_unf = 0;
    end else begin
      old = q.size();
      wa = w && (old != DEPTH);
      ra = r && !m_empty;
      if (w && old == DEPTH) m_ovf = 1;
      if (r && m_empty) m_unf = 1;
      if (ra) m_dout0 = q.pop_front();
      if (wa) q.push_back(d);
      m_empty = ((old - int'(ra)) == 0);
    end
  endtask

  task automatic step(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    wr_en = w; rd_en = r; clr = c; din = d;
    @(posedge clk);
    model(w, r, c, d);
    @(negedge clk);
    check_all();
    wr_en = 0; rd_en = 0; clr = 0;
  endtask

  // Called just after a falling edge; reset lands between clock edges.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    q.delete(); m_empty = 1; m_ovf = 0; m_unf = 0; m_dout0 = '0;
    check_all();
    chk("rst_dout1", f1_dout, '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] w0;
    @(negedge clk);
    do_reset();

    // Single write: count now, data and !empty one edge later
    step(1, 0, 0, 72'hA5);
    chk("t1_cnt", DW'(f1_cnt), 72'd1);
    chk("t1_empty_early", DW'(f1_empty), 72'd1);
    step(0, 0, 0, '0);
    chk("t1_empty", DW'(f1_empty), 72'd0);
    chk("t1_dout", f1_dout, 72'hA5);

    // Fill, overflow, drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, rnd72());
    chk("t2_full", DW'(f1_full), 72'd1);
    chk("t2_cnt", DW'(f1_cnt), 72'd64);
    step(1, 0, 0, rnd72());
    chk("t2_ovf", DW'(f1_ovf), 72'd1);
    chk("t2_cnt65", DW'(f1_cnt), 72'd64);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, '0);
    chk("t2_drained", DW'(f1_empty), 72'd1);

    // Steady state at 10 across pointer wrap
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, rnd72());
    step(0, 0, 0, '0);
    for (int i = 0; i < 100; i++) step(1, 1, 0, rnd72());
    chk("t3_cnt", DW'(f1_cnt), 72'd10);

    // Watermark ramp
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, rnd72());
      if (i == 3)  chk("t4_ae4", DW'(f1_ae), 72'd1);
      if (i == 4)  chk("t4_ae5", DW'(f1_ae), 72'd0);
      if (i == 46) chk("t4_af47", DW'(f1_af), 72'd0);
      if (i == 47) chk("t4_af48", DW'(f1_af), 72'd1);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 0, '0);

    // Standard-read latency and underflow
    do_reset();
    step(1, 0, 0, 72'h11); step(1, 0, 0, 72'h22); step(1, 0, 0, 72'h33);
    step(0, 0, 0, '0);
    step(0, 1, 0, '0);
    chk("t5_word0", f0_dout, 72'h11);
    step(0, 0, 0, '0);
    chk("t5_hold", f0_dout, 72'h11);
    step(0, 1, 0, '0); step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    chk("t5_unf", DW'(f0_unf), 72'd1);
    chk("t5_dout_kept", f0_dout, 72'h33);

    // Clear and mid-burst async reset
    do_reset();
    step(0, 1, 0, '0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, rnd72());
    step(1, 1, 1, rnd72());
    chk("t6_clr_cnt", DW'(f1_cnt), 72'd0);
    chk("t6_clr_unf", DW'(f1_unf), 72'd0);
    step(1, 0, 0, 72'h77);
    step(0, 0, 0, '0);
    chk("t6_clr_dout", f1_dout, 72'h77);
    for (int i = 0; i < 15; i++) step(1, i[0], 0, rnd72());
    do_reset();
    chk("t6_rst_cnt", DW'(f1_cnt), 72'd0);
    w0 = rnd72();
    step(1, 0, 0, w0);
    step(0, 0, 0, '0);
    chk("t6_rst_dout1", f1_dout, w0);
    step(0, 1, 0, '0);
    chk("t6_rst_dout0", f0_dout, w0);

    // Random traffic with shifting write/read bias
    for (int p = 0; p < 6; p++) begin
      int wb, rb;
      wb = (p % 3 == 0) ? 80 : (p % 3 == 1) ? 30 : 55;
      rb = 100 - wb;
      for (int i = 0; i < 400; i++)
        step($urandom_range(99) < wb, $urandom_range(99) < rb,
             $urandom_range(299) == 0, rnd72());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
